// File: rtl/load_align_unit.sv
// Load-alignment unit for the memory stage: accepts one load at a time,
// issues word-aligned bus reads (two beats for word-crossing loads), merges
// and extends the result, and returns it with a fault flag and tag.

package load_align_pkg;
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_BYTE_U = 3'd1,
    MEM_HALF   = 3'd2,
    MEM_HALF_U = 3'd3,
    MEM_WORD   = 3'd4
  } mem_op_e;
endpackage

module load_align_unit
  import load_align_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TAG_W          = 5,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_addr,
  input  mem_op_e          req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic             rsp_fault,
  output logic [TAG_W-1:0] rsp_tag
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
  } state_e;

  state_e             r_state, w_state_nxt;
  mem_op_e            r_op;
  logic [1:0]         r_off;
  logic               r_cross;
  logic [XLEN-1:0]    r_beat0;
  logic               r_mem_req, w_mem_req_nxt;
  logic [XLEN-1:0]    r_mem_addr, w_mem_addr_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [XLEN-1:0]    r_rsp_data, w_rsp_data_nxt;
  logic               r_rsp_fault, w_rsp_fault_nxt;
  logic [TAG_W-1:0]   r_rsp_tag, w_rsp_tag_nxt;
  logic               w_accept, w_beat0_we;
  logic [2:0]         w_size;
  logic               w_legal_op, w_misal, w_cross, w_fault_req;

  // Shift the two-beat window down to the byte offset, then extend by op.
  function automatic logic [XLEN-1:0] align_extend(input mem_op_e op, input logic [1:0] off,
                                                   input logic [XLEN-1:0] lo, input logic [XLEN-1:0] hi);
    logic [XLEN-1:0] m;
    m = XLEN'({hi, lo} >> {off, 3'b000});
    case (op)
      MEM_BYTE:   return {{(XLEN-8){m[7]}}, m[7:0]};
      MEM_BYTE_U: return {{(XLEN-8){1'b0}}, m[7:0]};
      MEM_HALF:   return {{(XLEN-16){m[15]}}, m[15:0]};
      MEM_HALF_U: return {{(XLEN-16){1'b0}}, m[15:0]};
      default:    return m;
    endcase
  endfunction

  // Decode the incoming request: access size, legality, misalignment, crossing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_size     = 3'd0;
    w_legal_op = 1'b1;
    case (req_op)
      MEM_BYTE, MEM_BYTE_U: w_size = 3'd1;
      MEM_HALF, MEM_HALF_U: w_size = 3'd2;
      MEM_WORD:             w_size = 3'd4;
      default:              w_legal_op = 1'b0;
    endcase
    w_misal     = ((w_size == 3'd2) && req_addr[0]) ||
                  ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
    w_cross     = ({1'b0, req_addr[1:0]} + w_size) > 3'd4;
    w_fault_req = !w_legal_op || (!MISALIGN_SPLIT && w_misal);
  end

  // Next-state and next values of all registered outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_fault_nxt = r_rsp_fault;
    w_rsp_tag_nxt   = r_rsp_tag;
    w_accept        = 1'b0;
    w_beat0_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept      = 1'b1;
          w_rsp_tag_nxt = req_tag;
          if (w_fault_req) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_fault_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
          end else begin
            w_state_nxt    = S_REQ0;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {req_addr[XLEN-1:2], 2'b00};
          end
        end
      end
      S_REQ0: begin
        if (mem_gnt) begin
          w_state_nxt   = S_WAIT0;
          w_mem_req_nxt = 1'b0;
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          w_beat0_we = 1'b1;
          if (mem_err) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_fault_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
          end else if (r_cross) begin
            w_state_nxt    = S_REQ1;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_mem_addr + XLEN'(4);  // wraps naturally past the top word
          end else begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_fault_nxt = 1'b0;
            w_rsp_data_nxt  = align_extend(r_op, r_off, mem_rdata, '0);
          end
        end
      end
      S_REQ1: begin
        if (mem_gnt) begin
          w_state_nxt   = S_WAIT1;
          w_mem_req_nxt = 1'b0;
        end
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_fault_nxt = mem_err;
          w_rsp_data_nxt  = mem_err ? '0 : align_extend(r_op, r_off, r_beat0, mem_rdata);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= MEM_BYTE;
      r_off       <= 2'b00;
      r_cross     <= 1'b0;
      r_beat0     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_fault <= w_rsp_fault_nxt;
      r_rsp_tag   <= w_rsp_tag_nxt;
      if (w_accept) begin
        r_op    <= req_op;
        r_off   <= req_addr[1:0];
        r_cross <= w_cross;
      end
      if (w_beat0_we) begin
        r_beat0 <= mem_rdata;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;
  assign rsp_tag   = r_rsp_tag;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one split-mode instance and one
// trap-mode instance, with hand-computed expected responses.

module tb_load_align_unit;
  import load_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Split-mode instance
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  mem_op_e     req_op = MEM_BYTE;
  logic [4:0]  req_tag = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_fault;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;

  // Trap-mode instance
  logic        t_req_valid = 1'b0, t_req_ready;
  logic [31:0] t_req_addr = '0;
  mem_op_e     t_req_op = MEM_BYTE;
  logic [4:0]  t_req_tag = '0;
  logic        t_mem_req;
  logic [31:0] t_mem_addr;
  logic        t_mem_gnt = 1'b0, t_mem_rvalid = 1'b0, t_mem_err = 1'b0;
  logic [31:0] t_mem_rdata = '0;
  logic        t_rsp_valid, t_rsp_ready = 1'b0, t_rsp_fault;
  logic [31:0] t_rsp_data;
  logic [4:0]  t_rsp_tag;

  int n_checks = 0;
  int n_errors = 0;

  load_align_unit #(.XLEN(32), .TAG_W(5), .MISALIGN_SPLIT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_tag(req_tag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault), .rsp_tag(rsp_tag)
  );

  load_align_unit #(.XLEN(32), .TAG_W(5), .MISALIGN_SPLIT(1'b0)) u_dut_trap (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_addr(t_req_addr),
    .req_op(t_req_op), .req_tag(t_req_tag),
    .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_gnt(t_mem_gnt),
    .mem_rvalid(t_mem_rvalid), .mem_rdata(t_mem_rdata), .mem_err(t_mem_err),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
    .rsp_fault(t_rsp_fault), .rsp_tag(t_rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input mem_op_e op, input logic [4:0] tag);
    check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_op = op; req_tag = tag;
    tick();
    req_valid = 1'b0;
  endtask

  // Serve one bus beat: optional grant delay (checking request stability), then data.
  task automatic serve(input string nm, input logic [31:0] exp_addr, input logic [31:0] data,
                       input logic err, input int gnt_dly);
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check({nm, "_mem_req"}, 32'(mem_req), 32'd1);
    check({nm, "_mem_addr"}, mem_addr, exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      check({nm, "_req_hold"}, {31'd0, mem_req}, 32'd1);
      check({nm, "_addr_hold"}, mem_addr, exp_addr);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({nm, "_req_drop"}, 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = data; mem_err = err;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  // Response must be present now; check it, then handshake.
  task automatic take_rsp(input string nm, input logic [31:0] data, input logic fault, input logic [4:0] tag);
    check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({nm, "_rsp_data"}, rsp_data, data);
    check({nm, "_rsp_fault"}, 32'(rsp_fault), {31'd0, fault});
    check({nm, "_rsp_tag"}, 32'(rsp_tag), {27'd0, tag});
    check({nm, "_no_req"}, 32'(mem_req), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({nm, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({nm, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_t_req_ready", 32'(t_req_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // LB at 0x1003: byte 0x80 sign-extends; aligned timing (req@1, rvalid@2, rsp@3)
    issue("lb", 32'h0000_1003, MEM_BYTE, 5'h0A);
    serve("lb_b0", 32'h0000_1000, 32'h80AA_5511, 1'b0, 0);
    take_rsp("lb", 32'hFFFF_FF80, 1'b0, 5'h0A);

    // LBU at 0x1001: byte 0x55 zero-extends
    issue("lbu", 32'h0000_1001, MEM_BYTE_U, 5'h11);
    serve("lbu_b0", 32'h0000_1000, 32'h80AA_5511, 1'b0, 0);
    take_rsp("lbu", 32'h0000_0055, 1'b0, 5'h11);

    // LHU at 0x2003 crosses: reads 0x2000 then 0x2004, grant delayed on first beat
    issue("lhu", 32'h0000_2003, MEM_HALF_U, 5'h03);
    serve("lhu_b0", 32'h0000_2000, 32'hAB00_0000, 1'b0, 2);
    check("lhu_mid_rsp", 32'(rsp_valid), 32'd0);
    serve("lhu_b1", 32'h0000_2004, 32'h0000_00CD, 1'b0, 0);
    take_rsp("lhu", 32'h0000_CDAB, 1'b0, 5'h03);

    // LH at 0x6001: misaligned but not crossing, single read, sign-extended
    issue("lh_m", 32'h0000_6001, MEM_HALF, 5'h07);
    serve("lh_m_b0", 32'h0000_6000, 32'h00C0_FF00, 1'b0, 0);
    take_rsp("lh_m", 32'hFFFF_C0FF, 1'b0, 5'h07);

    // LW at 0xFFFFFFFE: second beat address wraps to 0
    issue("lw_wrap", 32'hFFFF_FFFE, MEM_WORD, 5'h1F);
    serve("lw_wrap_b0", 32'hFFFF_FFFC, 32'h3344_0000, 1'b0, 0);
    serve("lw_wrap_b1", 32'h0000_0000, 32'h0000_5566, 1'b0, 0);
    take_rsp("lw_wrap", 32'h5566_3344, 1'b0, 5'h1F);

    // Illegal op: fault at cycle 1, no bus access
    issue("ill", 32'h0000_0100, mem_op_e'(3'd7), 5'h15);
    take_rsp("ill", 32'h0000_0000, 1'b1, 5'h15);

    // Trap-mode instance: LH at 0x101 faults at cycle 1 with no bus access
    check("trap_req_ready", 32'(t_req_ready), 32'd1);
    t_req_valid = 1'b1; t_req_addr = 32'h0000_0101; t_req_op = MEM_HALF; t_req_tag = 5'h09;
    tick();
    t_req_valid = 1'b0;
    check("trap_rsp_valid", 32'(t_rsp_valid), 32'd1);
    check("trap_rsp_fault", 32'(t_rsp_fault), 32'd1);
    check("trap_rsp_data", t_rsp_data, 32'd0);
    check("trap_rsp_tag", 32'(t_rsp_tag), 32'h09);
    check("trap_mem_req", 32'(t_mem_req), 32'd0);
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
    check("trap_rsp_drop", 32'(t_rsp_valid), 32'd0);
    check("trap_mem_req_after", 32'(t_mem_req), 32'd0);

    // Bus error on beat0 of crossing LW: no second read, response held under backpressure
    issue("lw_err", 32'h0000_3001, MEM_WORD, 5'h0C);
    serve("lw_err_b0", 32'h0000_3000, 32'h1234_5678, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      check("err_hold_valid", 32'(rsp_valid), 32'd1);
      check("err_hold_fault", 32'(rsp_fault), 32'd1);
      check("err_hold_data", rsp_data, 32'd0);
      check("err_hold_ready", 32'(req_ready), 32'd0);
      check("err_hold_no_req", 32'(mem_req), 32'd0);
      tick();
    end
    take_rsp("lw_err", 32'h0000_0000, 1'b1, 5'h0C);

    // Reset during WAIT0, then a stray rvalid arrives in IDLE
    issue("rst_mid", 32'h0000_5000, MEM_WORD, 5'h02);
    check("rst_mid_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_mem_req", 32'(mem_req), 32'd0);
    check("stray_req_ready", 32'(req_ready), 32'd1);

    // Aligned LW after recovery
    issue("lw", 32'h0000_4000, MEM_WORD, 5'h16);
    serve("lw_b0", 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 0);
    take_rsp("lw", 32'hDEAD_BEEF, 1'b0, 5'h16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
